// File: rtl/conv2_wm_pkg.sv
// Shared constants and FSM encoding for the conv2 weight-memory controller.
package conv2_wm_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 8;
  localparam int DEPTH      = 200;

  typedef enum logic [1:0] {
    IDLE,
    RD_ISSUE,
    RD_DRAIN
  } state_t;

endpackage

// File: rtl/conv2_wm_ctrl_if.sv
// Client-side streams and macro port of the conv2 weight-memory controller.
interface conv2_wm_ctrl_if #(
  parameter int DW = conv2_wm_pkg::DATA_WIDTH,
  parameter int AW = conv2_wm_pkg::ADDR_WIDTH
);

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_start;
  logic [AW-1:0] rd_base;
  logic [AW-1:0] rd_len;
  logic          rd_busy;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          err;
  logic          err_clr;
  logic          csb0;
  logic          web0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0;

  // Controller side.
  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_start, rd_base, rd_len, err_clr, dout0,
    output wr_ready, rd_busy, rd_valid, rd_data, rd_last, err, csb0, web0, addr0, din0
  );

  // Loader, compute engine and macro side.
  modport master (
    output wr_valid, wr_addr, wr_data, rd_start, rd_base, rd_len, err_clr, dout0,
    input  wr_ready, rd_busy, rd_valid, rd_data, rd_last, err, csb0, web0, addr0, din0
  );

endinterface

// File: rtl/conv2_wm_rd_pipe.sv
// Realigns macro read data with the issue strobe: two-stage valid/last shift
// register followed by the rd_data capture flop.
module conv2_wm_rd_pipe #(
  parameter int DATA_WIDTH = conv2_wm_pkg::DATA_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rst_n,
  input  logic                  issue,
  input  logic                  issue_last,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  rd_valid,
  output logic                  rd_last,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [1:0] valid_sr;
  logic [1:0] last_sr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr <= '0;
      last_sr  <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else begin
      valid_sr <= {valid_sr[0], issue};
      last_sr  <= {last_sr[0], issue & issue_last};
      rd_valid <= valid_sr[1];
      rd_last  <= valid_sr[1] & last_sr[1];
      // Stage 1 coincides with the macro's output being settled.
      if (valid_sr[1]) rd_data <= dout0;
    end
  end

endmodule

// File: rtl/conv2_wm_ctrl.sv
// Arbitrates the single-port conv2 weight macro between the loader write
// stream and compute read bursts; all macro commands are registered.
module conv2_wm_ctrl #(
  parameter int DATA_WIDTH = conv2_wm_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = conv2_wm_pkg::ADDR_WIDTH,
  parameter int DEPTH      = conv2_wm_pkg::DEPTH
) (
  input  logic             clk0,
  input  logic             rst_n,
  conv2_wm_ctrl_if.slave   bus
);

  import conv2_wm_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == DEPTH_A - ONE_A) ? '0 : a + ONE_A;
  endfunction

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ctr_q, ctr_d;
  logic [ADDR_WIDTH-1:0]   rem_q, rem_d;
  logic                    err_q, err_d, err_set;
  logic                    csb_q, csb_d, web_q, web_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic                    issue, issue_last;
  logic                    rd_last;

  logic                    accept, wr_fire;
  logic [ADDR_WIDTH-1:0]   len_eff;

  // A legal read request always wins the port over a pending write.
  assign accept  = (state_q == IDLE) && bus.rd_start &&
                   (bus.rd_len != '0) && (bus.rd_base < DEPTH_A);
  assign len_eff = (bus.rd_len > DEPTH_A) ? DEPTH_A : bus.rd_len;

  assign bus.wr_ready = rst_n && (state_q == IDLE) && !accept;
  assign wr_fire      = bus.wr_valid && bus.wr_ready;

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept)         state_d = RD_ISSUE;
      RD_ISSUE: if (rem_q <= ONE_A) state_d = RD_DRAIN;
      RD_DRAIN: if (rd_last)        state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    ctr_d      = ctr_q;
    rem_d      = rem_q;
    csb_d      = 1'b1;
    web_d      = 1'b1;
    addr_d     = addr_q;
    din_d      = din_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    err_set    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          issue      = 1'b1;
          issue_last = (len_eff == ONE_A);
          csb_d      = 1'b0;
          addr_d     = bus.rd_base;
          ctr_d      = wrap_inc(bus.rd_base);
          rem_d      = len_eff - ONE_A;
          err_set    = (bus.rd_len > DEPTH_A);
        end else if (bus.rd_start) begin
          err_set = 1'b1;
        end
        if (wr_fire) begin
          if (bus.wr_addr < DEPTH_A) begin
            csb_d  = 1'b0;
            web_d  = 1'b0;
            addr_d = bus.wr_addr;
            din_d  = bus.wr_data;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      RD_ISSUE: begin
        if (rem_q != '0) begin
          issue      = 1'b1;
          issue_last = (rem_q == ONE_A);
          csb_d      = 1'b0;
          addr_d     = ctr_q;
          ctr_d      = wrap_inc(ctr_q);
          rem_d      = rem_q - ONE_A;
        end
      end
      default: ;
    endcase
    err_d = (err_q && !bus.err_clr) || err_set;
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q  <= '0;
      rem_q  <= '0;
      err_q  <= 1'b0;
      csb_q  <= 1'b1;
      web_q  <= 1'b1;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      ctr_q  <= ctr_d;
      rem_q  <= rem_d;
      err_q  <= err_d;
      csb_q  <= csb_d;
      web_q  <= web_d;
      addr_q <= addr_d;
      din_q  <= din_d;
    end
  end

  assign bus.csb0    = csb_q;
  assign bus.web0    = web_q;
  assign bus.addr0   = addr_q;
  assign bus.din0    = din_q;
  assign bus.err     = err_q;
  assign bus.rd_busy = (state_q != IDLE);
  assign bus.rd_last = rd_last;

  conv2_wm_rd_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_rd_pipe (
    .clk0       (clk0),
    .rst_n      (rst_n),
    .issue      (issue),
    .issue_last (issue_last),
    .dout0      (bus.dout0),
    .rd_valid   (bus.rd_valid),
    .rd_last    (rd_last),
    .rd_data    (bus.rd_data)
  );

endmodule

// File: doc/conv2_wm_ctrl.md
# conv2_wm_ctrl

Controller and arbiter for the conv2 weight-memory macro (`conv2_wm_sram_16_200_sky130A`, 16-bit × 200 words, single RW port). It shares the one port between a weight loader (write stream) and the conv2 compute engine (read bursts). It also registers every macro command so the setup timing at the macro's posedge input flops is met, and realigns the macro's read data into a valid/last stream.

## Interface
Parameters:
- DATA_WIDTH, 16, word width; must match the macro.
- ADDR_WIDTH, 8, macro address width.
- DEPTH, 200, number of implemented words; addresses ≥ DEPTH are illegal.

Ports:
- clk0  in  1  clock; same clock as the macro's clk0.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  loader presents a word.
- wr_ready  out  1  word accepted on an edge where wr_valid && wr_ready.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_start  in  1  burst request; a single-cycle pulse is sufficient.
- rd_base  in  ADDR_WIDTH  first burst address.
- rd_len  in  ADDR_WIDTH  number of words, 1..DEPTH.
- rd_busy  out  1  a burst is in progress.
- rd_valid  out  1  rd_data holds a burst word.
- rd_data  out  DATA_WIDTH  read word, registered.
- rd_last  out  1  marks the final word of a burst.
- err  out  1  sticky illegal-request flag.
- err_clr  in  1  synchronously clears err.
- csb0, web0  out  1  macro chip select and write enable, both active low, registered.
- addr0  out  ADDR_WIDTH  registered macro address.
- din0  out  DATA_WIDTH  registered macro write data.
- dout0  in  DATA_WIDTH  macro read data.

## Operation
- FSM states: IDLE, RD_ISSUE, RD_DRAIN.
- IDLE:
  - wr_ready = rst_n && state==IDLE && !(rd_start accepted this cycle).
  - A write handshake registers csb0=0, web0=1→0, addr0=wr_addr, din0=wr_data.
  - Back-to-back writes run at one per cycle.
- Arbitration: in IDLE, when rd_start and wr_valid are both asserted, the read wins. wr_ready is 0 on that edge and the loader holds its word.
- A burst is accepted from IDLE when rd_start=1, rd_len≠0 and rd_base<DEPTH. On acceptance:
  - the controller latches the address counter and remaining count;
  - the state goes to RD_ISSUE;
  - rd_busy goes to 1.
- RD_ISSUE issues one read per cycle (csb0=0, web0=1, addr0=counter).
  - The address increments modulo DEPTH: 199 wraps to 0.
  - After the final issue, the state goes to RD_DRAIN.
- RD_DRAIN waits until rd_last has been emitted, then returns to IDLE with rd_busy=0.
- rd_start outside IDLE is ignored and does not set err.
- Illegal requests:
  - A write with wr_addr ≥ DEPTH completes the handshake, issues no macro access (csb0 stays 1) and sets err.
  - rd_start with rd_base ≥ DEPTH or rd_len=0 is not accepted and sets err.
  - rd_len > DEPTH is clamped to DEPTH and sets err.
- err_clr and a new error in the same cycle: err stays 1.
- No access in a cycle: csb0=1, web0=1; addr0 and din0 hold their previous values.

## Timing
- Reset values: csb0=1, web0=1, addr0=0, din0=0, rd_valid=0, rd_last=0, rd_data=0, rd_busy=0, err=0, wr_ready=0; state IDLE.
- Macro commands change only on clk0 posedge and are held a full cycle. The macro samples them on the following posedge.
- Read latency:
  - rd_start sampled at edge E0 → the first read command is driven after E0.
  - The macro captures it at E0+1; dout0 is settled before E0+2.
  - The controller registers dout0 into rd_data at E0+2. rd_valid=1 during the cycle after E0+2.
  - Word k appears after edge E0+2+k.
  - rd_last accompanies word rd_len−1.
  - rd_busy falls on the edge after rd_last.
- Valid/last alignment uses a 2-stage shift register fed by the issue strobe.
- Writes: the handshake at edge E registers the command after E; the macro commits it at E+1 (posedge capture, negedge write).
- A write accepted in the cycle after rd_busy falls may target any address. There is no read-after-write bypass: a burst requested after a write sees the new data only if it is accepted at least one edge after the write handshake.
- Reset mid-burst: csb0 and web0 go to 1 asynchronously, the pipeline flushes, and no further rd_valid is produced.

## Structure
- Package conv2_wm_pkg holds DATA_WIDTH, ADDR_WIDTH, DEPTH and the state enum (IDLE, RD_ISSUE, RD_DRAIN).
- One sub-module, conv2_wm_rd_pipe: the 2-stage valid/last shift register plus the rd_data capture flop, with the same async reset.
- The top level holds the FSM, counters, arbitration and command registers.

## Test plan
- Write 0..199 with data = addr^16'hA5A5 back-to-back → wr_ready=1 on every cycle, 200 write commands, err=0.
- rd_base=0, rd_len=4 → rd_valid on cycles E0+3..E0+6 with data A5A5, A5A4, A5A7, A5A6; rd_last only on the 4th word; rd_busy low afterwards.
- rd_base=198, rd_len=4 → addr0 sequence 198, 199, 0, 1; data matches; rd_last on the 4th word.
- rd_start and wr_valid asserted in the same cycle → read accepted; wr_ready=0 until the burst drains; the held write completes the cycle after rd_busy falls.
- wr_addr=200, then rd_len=0, then rd_base=210 → no macro access (csb0=1) for all three; err=1 after the first; err_clr → err=0.
- Assert rst_n=0 during word 2 of an 8-word burst → csb0=1 immediately, rd_valid=0, no rd_last; after release, a new burst reads correctly.
